// File: rtl/imem_uart_loader_pkg.sv
// Shared types and constants for the UART instruction-memory loader.
package loader_pkg;

    // Loader frame-parsing states.
    typedef enum logic [1:0] {
        LD_IDLE,
        LD_LEN,
        LD_DATA
    } ld_state_t;

    // UART receiver states.
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // Default frame start marker.
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Instruction memory depth in words.
    localparam int MAX_WORDS = 64;

    // A length byte is acceptable when it does not exceed the memory depth.
    function automatic logic len_ok(input logic [7:0] n);
        return n <= 8'(MAX_WORDS);
    endfunction

    // Length byte to word count: zero encodes a full-memory load.
    function automatic logic [7:0] len_words(input logic [7:0] n);
        return (n == 8'd0) ? 8'(MAX_WORDS) : n;
    endfunction

endpackage

// File: rtl/imem_uart_loader_if.sv
// Serial line in, instruction-memory write port and load status out.
interface imem_uart_loader_if #(
    parameter int ADDR_W = 6
);
    logic              rxd;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              busy;
    logic              done;
    logic              frame_err;
    logic [ADDR_W:0]   word_cnt;

    // Loader side: consumes the serial line, drives the memory write port.
    modport master (
        input  rxd,
        output im_we,
        output im_addr,
        output im_wdata,
        output busy,
        output done,
        output frame_err,
        output word_cnt
    );

    // Host / memory side: drives the serial line, observes writes and status.
    modport slave (
        output rxd,
        input  im_we,
        input  im_addr,
        input  im_wdata,
        input  busy,
        input  done,
        input  frame_err,
        input  word_cnt
    );
endinterface

// File: rtl/imem_uart_loader_uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling, one-cycle
// byte_valid / byte_err pulses. Returns to idle at the stop-bit sample point.
module uart_rx
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic       byte_valid,
    output logic       byte_err,
    output logic [7:0] byte_data
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    // Next-state: start-bit qualification, LSB-first shifting, stop-bit check.
    always_comb begin
        sync1_d = rxd;
        sync2_d = sync1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                if (!sync2_q) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_M1) begin
                    // Line back high at mid start bit: a glitch, not a frame.
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = sync2_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    valid_d = sync2_q;
                    err_d   = !sync2_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    // Receiver registers; the synchroniser resets to the idle (high) level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign byte_valid = valid_q;
    assign byte_err   = err_q;
    assign byte_data  = shift_q;

endmodule

// File: rtl/imem_uart_loader.sv
// UART program loader: parses SYNC, length, then little-endian 32-bit words
// and writes them to consecutive instruction-memory addresses from 0.
module imem_uart_loader
    import loader_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 868,
    parameter int         ADDR_W       = 6,
    parameter logic [7:0] SYNC_BYTE    = loader_pkg::SYNC_BYTE
) (
    input  logic               clk,
    input  logic               rst,
    imem_uart_loader_if.master bus
);
    logic       rx_valid;
    logic       rx_err;
    logic [7:0] rx_data;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rxd       (bus.rxd),
        .byte_valid(rx_valid),
        .byte_err  (rx_err),
        .byte_data (rx_data)
    );

    ld_state_t         st_q, st_d;
    logic [1:0]        idx_q, idx_d;
    logic [23:0]       buf_q, buf_d;
    logic [ADDR_W:0]   total_q, total_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ferr_q, ferr_d;

    // Frame parser: sync detection, length validation, word assembly and write.
    always_comb begin
        st_d    = st_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        total_d = total_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        busy_d  = busy_q;
        done_d  = done_q;
        ferr_d  = ferr_q;
        unique case (st_q)
            LD_IDLE: begin
                // Framing errors and stray bytes between frames are ignored.
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    st_d   = LD_LEN;
                    busy_d = 1'b1;
                    done_d = 1'b0;
                    ferr_d = 1'b0;
                    cnt_d  = '0;
                    idx_d  = '0;
                end
            end
            LD_LEN: begin
                if (rx_err || (rx_valid && !len_ok(rx_data))) begin
                    st_d   = LD_IDLE;
                    ferr_d = 1'b1;
                    busy_d = 1'b0;
                end else if (rx_valid) begin
                    total_d = (ADDR_W + 1)'(len_words(rx_data));
                    st_d    = LD_DATA;
                end
            end
            LD_DATA: begin
                // Words already written stay written; word_cnt keeps that count.
                if (rx_err) begin
                    st_d   = LD_IDLE;
                    ferr_d = 1'b1;
                    busy_d = 1'b0;
                end else if (rx_valid) begin
                    if (idx_q != 2'd3) begin
                        buf_d[8*idx_q +: 8] = rx_data;
                        idx_d = idx_q + 2'd1;
                    end else begin
                        we_d    = 1'b1;
                        addr_d  = cnt_q[ADDR_W-1:0];
                        wdata_d = {rx_data, buf_q};
                        cnt_d   = cnt_q + (ADDR_W + 1)'(1);
                        idx_d   = '0;
                        if (cnt_q + (ADDR_W + 1)'(1) == total_q) begin
                            st_d   = LD_IDLE;
                            busy_d = 1'b0;
                            done_d = 1'b1;
                        end
                    end
                end
            end
            default: st_d = LD_IDLE;
        endcase
    end

    // Loader state and registered outputs; reset abandons any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q    <= LD_IDLE;
            idx_q   <= '0;
            buf_q   <= '0;
            total_q <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            st_q    <= st_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            total_q <= total_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    assign bus.im_we     = we_q;
    assign bus.im_addr   = addr_q;
    assign bus.im_wdata  = wdata_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.frame_err = ferr_q;
    assign bus.word_cnt  = cnt_q;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Bench for imem_uart_loader: serial frames driven on rxd, byte-level frame
// model predicts the memory writes and status flags.
module tb_imem_uart_loader;
    localparam int CPB    = 8;
    localparam int ADDR_W = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imem_uart_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_uart_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W      (ADDR_W),
        .SYNC_BYTE   (8'hA5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state (frame rules at byte granularity).
    int          m_state;     // 0 waiting for sync, 1 expecting length, 2 data
    int          m_total;
    int          m_cnt;
    bit          m_busy, m_done, m_ferr;
    logic [5:0]  m_last_addr;
    logic [31:0] m_last_data;
    logic [7:0]  bq[$];
    logic [37:0] exp_q[$];
    logic [37:0] got_q[$];

    logic prev_we = 1'b0;
    int   pulse_err = 0;

    // Capture every write strobe and flag any strobe wider than one cycle.
    always @(negedge clk) begin
        if (bus.im_we === 1'b1) begin
            got_q.push_back({bus.im_addr, bus.im_wdata});
            if (prev_we) pulse_err <= pulse_err + 1;
        end
        prev_we <= (bus.im_we === 1'b1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_total = 0; m_cnt = 0;
        m_busy = 0; m_done = 0; m_ferr = 0;
        m_last_addr = '0; m_last_data = '0;
        bq.delete();
        exp_q.delete();
    endtask

    task automatic model_abort();
        m_state = 0; m_ferr = 1; m_busy = 0;
    endtask

    task automatic model_byte(input logic [7:0] b, input bit ok);
        logic [31:0] w;
        case (m_state)
            0: if (ok && b == 8'hA5) begin
                m_state = 1; m_busy = 1; m_done = 0; m_ferr = 0; m_cnt = 0;
                bq.delete();
            end
            1: if (!ok || b > 8'd64) model_abort();
               else begin
                   m_total = (b == 8'd0) ? 64 : int'(b);
                   m_state = 2;
               end
            default: if (!ok) model_abort();
               else begin
                   bq.push_back(b);
                   if (bq.size() == 4) begin
                       w = {bq[3], bq[2], bq[1], bq[0]};
                       m_last_addr = 6'(m_cnt);
                       m_last_data = w;
                       exp_q.push_back({m_last_addr, w});
                       m_cnt++;
                       bq.delete();
                       if (m_cnt == m_total) begin
                           m_state = 0; m_busy = 0; m_done = 1;
                       end
                   end
               end
        endcase
    endtask

    task automatic drive_bit(input logic v, input int n);
        bus.rxd = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit ok);
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive_bit(b[i], CPB);
        if (ok) drive_bit(1'b1, CPB);
        else begin
            // Low across the stop sample point, then idle well before the
            // receiver could qualify it as a new start bit.
            drive_bit(1'b0, CPB / 2 + 2);
            drive_bit(1'b1, CPB / 2 - 2 + CPB);
        end
        model_byte(b, ok);
    endtask

    task automatic send_rand_frame(input int n);
        send_byte(8'hA5, 1);
        send_byte(8'(n), 1);
        for (int i = 0; i < 4 * n; i++) send_byte(8'($urandom), 1);
    endtask

    task automatic check_state(input string tag);
        int n;
        repeat (2 * CPB) @(negedge clk);
        chk({tag, "_nwrites"}, 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk({tag, "_write"}, 64'(got_q[i]), 64'(exp_q[i]));
        chk({tag, "_im_we"},     64'(bus.im_we),     64'(0));
        chk({tag, "_busy"},      64'(bus.busy),      64'(m_busy));
        chk({tag, "_done"},      64'(bus.done),      64'(m_done));
        chk({tag, "_frame_err"}, 64'(bus.frame_err), 64'(m_ferr));
        chk({tag, "_word_cnt"},  64'(bus.word_cnt),  64'(m_cnt));
        chk({tag, "_im_addr"},   64'(bus.im_addr),   64'(m_last_addr));
        chk({tag, "_im_wdata"},  64'(bus.im_wdata),  64'(m_last_data));
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b1;
        bus.rxd = 1'b1;
        model_reset();
        repeat (5) @(negedge clk);
        rst = 1'b0;

        // Idle line after reset: nothing happens for 20 bit times.
        repeat (20 * CPB) @(negedge clk);
        check_state("reset");

        // Single word.
        send_byte(8'hA5, 1); send_byte(8'h01, 1);
        send_byte(8'h78, 1); send_byte(8'h56, 1); send_byte(8'h34, 1); send_byte(8'h12, 1);
        chk("one_word_data", 64'(bus.im_wdata), 64'h12345678);
        check_state("one_word");

        // Junk before sync, then two random words.
        send_byte(8'h00, 1); send_byte(8'hFF, 1); send_byte(8'h3C, 1);
        send_rand_frame(2);
        check_state("two_words");

        // Full memory via length 0; word k = k.
        send_byte(8'hA5, 1); send_byte(8'h00, 1);
        for (int k = 0; k < 64; k++) begin
            send_byte(8'(k), 1); send_byte(8'h00, 1); send_byte(8'h00, 1); send_byte(8'h00, 1);
            if (k == 31) begin
                repeat (2 * CPB) @(negedge clk);
                chk("full_mid_busy", 64'(bus.busy), 64'(m_busy));
                chk("full_mid_cnt",  64'(bus.word_cnt), 64'(m_cnt));
            end
        end
        check_state("full64");

        // Stop-bit error mid data.
        send_byte(8'hA5, 1); send_byte(8'h03, 1);
        for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1);
        send_byte(8'($urandom), 0);
        check_state("stop_err");
        send_rand_frame(int'($urandom_range(1, 4)));
        check_state("recover");

        // Short low glitch in idle must not start a frame.
        drive_bit(1'b0, CPB / 4);
        drive_bit(1'b1, 4 * CPB);
        check_state("glitch");

        // Oversized length.
        send_byte(8'hA5, 1); send_byte(8'h41, 1);
        check_state("len_err");

        // Reset in the middle of the data phase.
        send_byte(8'hA5, 1); send_byte(8'h04, 1);
        for (int i = 0; i < 6; i++) send_byte(8'($urandom), 1);
        repeat (2 * CPB) @(negedge clk);
        chk("pre_rst_nwrites", 64'(got_q.size()), 64'(exp_q.size()));
        got_q.delete();
        rst = 1'b1;
        #1;
        chk("rst_busy",  64'(bus.busy),      64'(0));
        chk("rst_cnt",   64'(bus.word_cnt),  64'(0));
        chk("rst_addr",  64'(bus.im_addr),   64'(0));
        chk("rst_wdata", 64'(bus.im_wdata),  64'(0));
        chk("rst_ferr",  64'(bus.frame_err), 64'(0));
        chk("rst_done",  64'(bus.done),      64'(0));
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_no_we", 64'(got_q.size()), 64'(0));
        rst = 1'b0;
        repeat (2 * CPB) @(negedge clk);
        send_rand_frame(int'($urandom_range(1, 6)));
        check_state("after_rst");

        chk("we_width", 64'(pulse_err), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_uart_loader.md
# imem_uart_loader

Serial program loader for the single-cycle RISC-V FPGA design. Receives a framed program image over a UART line (8N1), assembles little-endian 32-bit instruction words and drives the write port of the 64-word instruction memory. It holds the CPU clock gate (`busy`) while loading so that a new program can be dropped in without re-synthesising the IM.

## Interface
- `CLKS_PER_BIT`, 868, board clock cycles per UART bit (100 MHz / 115200); must be ≥ 4.
- `ADDR_W`, 6, instruction-memory word address width (64 words).
- `SYNC_BYTE`, 8'hA5, frame start marker.

- `clk`  in  1  board clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rxd`  in  1  UART receive line, idle high, asynchronous to `clk`.
- `im_we`  out  1  one-cycle instruction-memory write strobe.
- `im_addr`  out  ADDR_W  word address for `im_we`.
- `im_wdata`  out  32  instruction word for `im_we`.
- `busy`  out  1  high from accepted sync byte until the last word is written or the load aborts; gates `Clk_CPU`.
- `done`  out  1  sticky: last load completed cleanly.
- `frame_err`  out  1  sticky: last load aborted (bad stop bit or bad length).
- `word_cnt`  out  ADDR_W+1  words written in the current/last load.

## Operation
- Frame: `SYNC_BYTE`, length byte N, then 4·N data bytes. N=0 means 64 words; N in 1..64 literal; N>64 is a length error.
- Word assembly little-endian: byte 0 → [7:0] … byte 3 → [31:24]. Word k written to `im_addr` = k, k from 0.
- Receiver: `rxd` through a 2-flop synchroniser. Idle waits for low level; start bit re-sampled at CLKS_PER_BIT/2 — if high, treated as glitch, back to idle. 8 data bits sampled LSB first every CLKS_PER_BIT thereafter, then stop bit. Stop=1 → `byte_valid` one-cycle pulse with `byte_data`; stop=0 → `byte_err` pulse, byte discarded. Receiver returns to idle at the stop-bit sample point (no wait for full stop bit).
- Loader FSM states: IDLE → (byte == SYNC_BYTE) → LEN → (valid N) → DATA → (last word written) → IDLE.
  - IDLE: all non-sync bytes and `byte_err` ignored.
  - Sync accepted: `busy`←1, `done`←0, `frame_err`←0, `word_cnt`←0, byte index←0.
  - LEN: N>64 or `byte_err` → IDLE, `frame_err`←1, `busy`←0.
  - DATA: `byte_err` → IDLE, `frame_err`←1, `busy`←0; words already written stay written, `word_cnt` holds count written.
  - Last word: `busy`←0 and `done`←1 in the same cycle as its `im_we`.
- A sync byte arriving in LEN/DATA is data, not a restart.
- `word_cnt` increments with each `im_we`; saturates naturally at 64.

## Timing
- Reset: `im_we`=0, `im_addr`=0, `im_wdata`=0, `busy`=0, `done`=0, `frame_err`=0, `word_cnt`=0, FSM IDLE, receiver idle. Reset mid-load abandons the frame immediately; no partial write strobe.
- Synchroniser latency 2 cycles; byte valid at stop-bit mid-point (≈9.5 bit times after start edge + 2).
- `im_we` registered: asserted the cycle after the 4th byte's `byte_valid`, high exactly 1 cycle; `im_addr`/`im_wdata` valid in that cycle and held until the next write.
- Minimum spacing between `im_we` pulses is 4 byte times; no back-pressure, IM write port accepts every cycle.
- `busy`, `done`, `frame_err` change only on the listed events, all registered.

## Structure
- Shared package `loader_pkg`: loader state enum (IDLE, LEN, DATA), `SYNC_BYTE`, max word count 64.
- Sub-module `uart_rx` (synchroniser, bit counter, baud counter, outputs `byte_valid`, `byte_data[7:0]`, `byte_err`); loader FSM and word assembly in `imem_uart_loader`.

## Test plan
- Reset with `rxd`=1 → all outputs 0 for 20 bit-times; no `im_we`.
- Send A5 01 78 56 34 12 → single `im_we` at addr 0, data 32'h12345678; `done`=1, `busy`=0, `word_cnt`=1.
- Send 00 FF 3C then A5 02 + 8 bytes → bytes before A5 ignored; writes at addr 0 and 1; `word_cnt`=2.
- Send A5 00 + 256 bytes (word k = k) → 64 writes, last addr 63 data 32'h0000003F, `word_cnt`=64, `done`=1.
- Send A5 03, then 5 good bytes, then a byte with stop=0 → one write at addr 0, `frame_err`=1, `busy`=0, `done`=0, `word_cnt`=1; following valid frame clears `frame_err`.
- Low pulse on `rxd` of CLKS_PER_BIT/4 in IDLE → no byte; A5 41 → `frame_err`=1 (length error); assert `rst` mid-DATA → outputs return to reset values next edge.
